// File: rtl/park_pkg.sv
// Shared types and defaults for the parking system.
// Used by the gate controller and by the full-light and display blocks.
package park_pkg;

   localparam int PARK_CAPACITY  = 15;
   localparam int PARK_CNT_W     = 4;
   localparam int PARK_GATE_HOLD = 8;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ENTRY_OPEN = 2'd1,
      EXIT_OPEN  = 2'd2
   } park_state_t;

endpackage

// File: rtl/park_sensor_filter.sv
// Per-sensor front end: optional debounce followed by rising-edge detect.
// Build option PARK_DEBOUNCE_EN adds the debounce filter; without it the raw
// sensor level drives the edge detector directly.
module park_sensor_filter
`ifdef PARK_DEBOUNCE_EN
#(
   parameter int DEBOUNCE_CYCLES = 4
)
`endif
(
   input  logic clk,
   input  logic rst,
   input  logic sensor_i,
   output logic level_o,
   output logic rise_o
);

   logic prev_q;

`ifdef PARK_DEBOUNCE_EN
   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE_CYCLES - 1);

   logic            filt_q;
   logic [DB_W-1:0] db_cnt_q;

   // Filtered level flips only after DEBOUNCE_CYCLES consecutive differing samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt_q   <= 1'b0;
         db_cnt_q <= DB_LOAD;
      end else if (sensor_i == filt_q) begin
         db_cnt_q <= DB_LOAD;
      end else if (db_cnt_q == '0) begin
         filt_q   <= sensor_i;
         db_cnt_q <= DB_LOAD;
      end else begin
         db_cnt_q <= db_cnt_q - 1'b1;
      end
   end

   assign level_o = filt_q;
`else
   assign level_o = sensor_i;
`endif

   // Previous level for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev_q <= 1'b0;
      else     prev_q <= level_o;
   end

   assign rise_o = level_o & ~prev_q;

endmodule

// File: rtl/parking_gate_controller.sv
// Parking gate sequencer: serves entry/exit requests, drives gate commands and
// keeps the saturating occupancy count.
// Build option PARK_DEBOUNCE_EN debounces both sensors before edge detection.
//
//  state      | meaning
//  -----------+------------------------------------------------------------
//  IDLE       | no gate open; pending/new requests arbitrated, exit first
//  ENTRY_OPEN | entry gate open; closes after GATE_HOLD low cycles, count +1
//  EXIT_OPEN  | exit gate open; closes after GATE_HOLD low cycles, count -1
module parking_gate_controller
   import park_pkg::*;
#(
   parameter int CAPACITY  = PARK_CAPACITY,
   parameter int CNT_W     = PARK_CNT_W,
`ifdef PARK_DEBOUNCE_EN
   parameter int DEBOUNCE_CYCLES = 4,
`endif
   parameter int GATE_HOLD = PARK_GATE_HOLD
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enter_sensor,
   input  logic             exit_sensor,
   output logic [CNT_W-1:0] occupancy,
   output logic             full,
   output logic             empty,
   output logic             gate_in_open,
   output logic             gate_out_open,
   output logic             reject_pulse
);

   localparam int HOLD_W = (GATE_HOLD > 1) ? $clog2(GATE_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(GATE_HOLD - 1);
   localparam logic [CNT_W-1:0]  CAP       = CNT_W'(CAPACITY);

   logic enter_level, enter_rise;
   logic exit_level, exit_rise;

   park_state_t       state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [CNT_W-1:0]  occ_q, occ_d;
   logic              pend_enter_q, pend_enter_d;
   logic              pend_exit_q, pend_exit_d;
   logic              gate_in_q, gate_in_d;
   logic              gate_out_q, gate_out_d;
   logic              reject_q, reject_d;
   logic              entry_req, exit_req;

`ifdef PARK_DEBOUNCE_EN
   park_sensor_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_filt (
`else
   park_sensor_filter u_enter_filt (
`endif
      .clk      (clk),
      .rst      (rst),
      .sensor_i (enter_sensor),
      .level_o  (enter_level),
      .rise_o   (enter_rise)
   );

`ifdef PARK_DEBOUNCE_EN
   park_sensor_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit_filt (
`else
   park_sensor_filter u_exit_filt (
`endif
      .clk      (clk),
      .rst      (rst),
      .sensor_i (exit_sensor),
      .level_o  (exit_level),
      .rise_o   (exit_rise)
   );

   assign full  = (occ_q == CAP);
   assign empty = (occ_q == '0);

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         hold_q       <= HOLD_LOAD;
         occ_q        <= '0;
         pend_enter_q <= 1'b0;
         pend_exit_q  <= 1'b0;
         gate_in_q    <= 1'b0;
         gate_out_q   <= 1'b0;
         reject_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         occ_q        <= occ_d;
         pend_enter_q <= pend_enter_d;
         pend_exit_q  <= pend_exit_d;
         gate_in_q    <= gate_in_d;
         gate_out_q   <= gate_out_d;
         reject_q     <= reject_d;
      end
   end

   // Request arbitration, gate hold timing and occupancy update.
   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      occ_d        = occ_q;
      pend_enter_d = pend_enter_q;
      pend_exit_d  = pend_exit_q;
      gate_in_d    = 1'b0;
      gate_out_d   = 1'b0;
      reject_d     = 1'b0;
      entry_req    = enter_rise | pend_enter_q;
      exit_req     = exit_rise | pend_exit_q;

      case (state_q)
         IDLE: begin
            pend_exit_d = 1'b0;
            if (exit_req && !empty) begin
               state_d    = EXIT_OPEN;
               gate_out_d = 1'b1;
               hold_d     = HOLD_LOAD;
               if (enter_rise) pend_enter_d = 1'b1;
            end else if (entry_req && !full) begin
               state_d      = ENTRY_OPEN;
               gate_in_d    = 1'b1;
               hold_d       = HOLD_LOAD;
               pend_enter_d = 1'b0;
            end else if (entry_req) begin
               reject_d     = 1'b1;
               pend_enter_d = 1'b0;
            end
         end

         ENTRY_OPEN: begin
            gate_in_d = 1'b1;
            if (exit_rise) pend_exit_d = 1'b1;
            if (enter_level) begin
               hold_d = HOLD_LOAD;
            end else if (hold_q == '0) begin
               gate_in_d = 1'b0;
               state_d   = IDLE;
               if (occ_q < CAP) occ_d = occ_q + 1'b1;
            end else begin
               hold_d = hold_q - 1'b1;
            end
         end

         EXIT_OPEN: begin
            gate_out_d = 1'b1;
            if (enter_rise) pend_enter_d = 1'b1;
            if (exit_level) begin
               hold_d = HOLD_LOAD;
            end else if (hold_q == '0) begin
               gate_out_d = 1'b0;
               state_d    = IDLE;
               if (occ_q != '0) occ_d = occ_q - 1'b1;
            end else begin
               hold_d = hold_q - 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign occupancy     = occ_q;
   assign gate_in_open  = gate_in_q;
   assign gate_out_open = gate_out_q;
   assign reject_pulse  = reject_q;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Bench for parking_gate_controller (default build, no sensor debounce).
// A behavioural lot model tracks what the outputs should be after every edge.
module tb_parking_gate_controller;

   localparam int CAP = 15;
   localparam int GH  = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       enter_sensor;
   logic       exit_sensor;
   logic [3:0] occupancy;
   logic       full, empty, gate_in_open, gate_out_open, reject_pulse;

   int checks = 0;
   int errors = 0;

   // Lot model: which gate is open (0 none, 1 entry, 2 exit), cars inside,
   // how long the serving sensor has been clear, and queued requests.
   int m_open;
   int m_cars;
   int m_clear_run;
   bit m_wait_in, m_wait_out;
   bit m_last_en, m_last_ex;
   bit m_reject;

   parking_gate_controller dut (
      .clk           (clk),
      .rst           (rst),
      .enter_sensor  (enter_sensor),
      .exit_sensor   (exit_sensor),
      .occupancy     (occupancy),
      .full          (full),
      .empty         (empty),
      .gate_in_open  (gate_in_open),
      .gate_out_open (gate_out_open),
      .reject_pulse  (reject_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_open = 0; m_cars = 0; m_clear_run = 0;
      m_wait_in = 0; m_wait_out = 0;
      m_last_en = 0; m_last_ex = 0; m_reject = 0;
   endtask

   task automatic model_step(input bit en, input bit ex);
      bit new_in, new_out;
      new_in  = en && !m_last_en;
      new_out = ex && !m_last_ex;
      m_reject = 0;
      if (m_open == 0) begin
         if ((new_out || m_wait_out) && m_cars > 0) begin
            m_open = 2; m_clear_run = 0;
            if (new_in) m_wait_in = 1;
         end else if (new_in || m_wait_in) begin
            if (m_cars < CAP) begin
               m_open = 1; m_clear_run = 0;
            end else begin
               m_reject = 1;
            end
            m_wait_in = 0;
         end
         m_wait_out = 0;
      end else if (m_open == 1) begin
         if (new_out) m_wait_out = 1;
         m_clear_run = en ? 0 : m_clear_run + 1;
         if (m_clear_run == GH) begin
            m_open = 0;
            m_cars = m_cars + 1;
         end
      end else begin
         if (new_in) m_wait_in = 1;
         m_clear_run = ex ? 0 : m_clear_run + 1;
         if (m_clear_run == GH) begin
            m_open = 0;
            m_cars = m_cars - 1;
         end
      end
      m_last_en = en;
      m_last_ex = ex;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".occ"},      16'(occupancy),     16'(m_cars));
      check({tag, ".full"},     16'(full),          16'(m_cars == CAP));
      check({tag, ".empty"},    16'(empty),         16'(m_cars == 0));
      check({tag, ".gate_in"},  16'(gate_in_open),  16'(m_open == 1));
      check({tag, ".gate_out"}, 16'(gate_out_open), 16'(m_open == 2));
      check({tag, ".reject"},   16'(reject_pulse),  16'(m_reject));
      check({tag, ".excl"},     16'(gate_in_open & gate_out_open), 16'd0);
   endtask

   task automatic cycle(input bit en, input bit ex, input string tag);
      enter_sensor = en;
      exit_sensor  = ex;
      @(posedge clk);
      model_step(en, ex);
      #1;
      check_outputs(tag);
   endtask

   task automatic car_in();
      cycle(1, 0, "in"); cycle(1, 0, "in");
      for (int i = 0; i < GH + 1; i++) cycle(0, 0, "in");
   endtask

   task automatic car_out();
      cycle(0, 1, "out"); cycle(0, 1, "out");
      for (int i = 0; i < GH + 1; i++) cycle(0, 0, "out");
   endtask

   initial begin
      bit en, ex;
      int rejects;

      rst = 1'b1;
      enter_sensor = 1'b0;
      exit_sensor  = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_outputs("reset");
      @(negedge clk);
      rst = 1'b0;

      // T2: single entry, gate opens one edge after the rise, closes after GH clear cycles
      cycle(1, 0, "t2");
      check("t2_open", 16'(gate_in_open), 16'd1);
      cycle(1, 0, "t2"); cycle(1, 0, "t2");
      for (int i = 0; i < GH - 1; i++) cycle(0, 0, "t2");
      check("t2_still_open", 16'(gate_in_open), 16'd1);
      cycle(0, 0, "t2");
      check("t2_closed", 16'(gate_in_open), 16'd0);
      check("t2_occ", 16'(occupancy), 16'd1);

      // T5a: exit request on an empty lot is dropped
      car_out();
      check("t5_empty", 16'(empty), 16'd1);
      cycle(0, 1, "t5");
      check("t5_no_gate", 16'(gate_out_open), 16'd0);
      cycle(0, 0, "t5"); cycle(0, 0, "t5");
      check("t5_occ0", 16'(occupancy), 16'd0);

      // T1: reset in the middle of an entry with five cars inside
      repeat (5) car_in();
      check("t1_occ5", 16'(occupancy), 16'd5);
      cycle(1, 0, "t1"); cycle(1, 0, "t1");
      #2;
      rst = 1'b1;
      enter_sensor = 1'b0;
      model_reset();
      #1;
      check_outputs("t1_rst");
      check("t1_occ", 16'(occupancy), 16'd0);
      @(negedge clk);
      rst = 1'b0;

      // T3/T5b: fill to capacity, next request is rejected for exactly one cycle
      repeat (CAP) car_in();
      check("t3_full", 16'(full), 16'd1);
      rejects = 0;
      cycle(1, 0, "t3");
      rejects += int'(reject_pulse);
      check("t3_no_gate", 16'(gate_in_open), 16'd0);
      for (int i = 0; i < 4; i++) begin
         cycle((i < 2), 0, "t3");
         rejects += int'(reject_pulse);
      end
      check("t3_one_reject", 16'(rejects), 16'd1);
      check("t3_occ", 16'(occupancy), 16'd15);

      // T4: simultaneous enter and exit at occupancy 3
      repeat (12) car_out();
      check("t4_occ3", 16'(occupancy), 16'd3);
      cycle(1, 1, "t4");
      check("t4_exit_first", 16'(gate_out_open), 16'd1);
      check("t4_no_entry", 16'(gate_in_open), 16'd0);
      cycle(1, 1, "t4");
      for (int i = 0; i < GH; i++) cycle(0, 0, "t4");
      check("t4_occ2", 16'(occupancy), 16'd2);
      cycle(0, 0, "t4");
      check("t4_pending_entry", 16'(gate_in_open), 16'd1);
      for (int i = 0; i < GH + 2; i++) cycle(0, 0, "t4");
      check("t4_occ3_again", 16'(occupancy), 16'd3);

      // Random traffic against the lot model
      en = 0; ex = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(4) == 0) en = ~en;
         if ($urandom_range(4) == 0) ex = ~ex;
         cycle(en, ex, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
